// File: rtl/sejf_pkg.sv
// Shared definitions for the safe combination sequencer: default parameters,
// state encoding and small state-decode helpers.
package sejf_pkg;

    localparam int DEF_DIAL_W      = 6;
    localparam int DEF_CODE0       = 10;
    localparam int DEF_CODE1       = 20;
    localparam int DEF_CODE2       = 30;
    localparam int DEF_MAX_FAIL    = 3;
    localparam int DEF_LOCKOUT_CYC = 1000;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_N0    = 4'd1,
        ST_N1    = 4'd2,
        ST_N2    = 4'd3,
        ST_CHECK = 4'd4,
        ST_LOCK  = 4'd5,
        ST_P0    = 4'd6,
        ST_P1    = 4'd7,
        ST_P2    = 4'd8
    } state_t;

    function automatic logic [1:0] state_idx(input state_t s);
        case (s)
            ST_N1, ST_P1: return 2'd1;
            ST_N2, ST_P2: return 2'd2;
            default:      return 2'd0;
        endcase
    endfunction

    function automatic logic state_busy(input state_t s);
        case (s)
            ST_N0, ST_N1, ST_N2, ST_CHECK, ST_P0, ST_P1, ST_P2: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Down-counter holding the sequencer in lockout: loaded with the lockout
// length minus one, counts while enabled, reports done at zero.
module lockout_timer #(
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    localparam int CNT_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;

    // Count register: load has priority, then saturating count-down.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= CNT_W'(LOCKOUT_CYC - 1);
        end else if (i_en && (r_cnt != {CNT_W{1'b0}})) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/combo_sequencer.sv
// One combination-entry attempt: tracks dial reversals, captures three numbers,
// compares them with the programmable code and enforces failure lockout.
module combo_sequencer
    import sejf_pkg::*;
#(
    parameter int DIAL_W      = DEF_DIAL_W,
    parameter int CODE0       = DEF_CODE0,
    parameter int CODE1       = DEF_CODE1,
    parameter int CODE2       = DEF_CODE2,
    parameter int MAX_FAIL    = DEF_MAX_FAIL,
    parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DIAL_W-1:0] i_dial,
    input  logic              i_step,
    input  logic              i_cw,
    input  logic              i_start,
    input  logic              i_confirm,
    input  logic              i_abort,
    input  logic              i_prog,
    input  logic              i_prog_en,
    output logic              o_clr_count,
    output logic              o_match,
    output logic              o_fail,
    output logic              o_prog_done,
    output logic [1:0]        o_idx,
    output logic              o_busy,
    output logic              o_lockout
);

    localparam int FC_W = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIAL_W-1:0] r_last;
    logic [DIAL_W-1:0] r_cap0, r_cap1, r_cap2;
    logic [DIAL_W-1:0] r_code0, r_code1, r_code2;
    logic              r_dir;
    logic              r_bad;
    logic [FC_W-1:0]   r_fail_cnt;

    logic w_pass, w_last_fail, w_p_cancel, w_timer_done, w_timer_load;
    logic w_clr_nxt, w_match_nxt, w_fail_nxt, w_prog_done_nxt;

    assign w_pass       = !r_bad && (r_cap0 == r_code0) && (r_cap1 == r_code1) && (r_cap2 == r_code2);
    assign w_last_fail  = (r_fail_cnt == FC_W'(MAX_FAIL - 1));
    // Losing programming permission mid-sequence behaves exactly like abort.
    assign w_p_cancel   = i_abort || !i_prog_en;
    assign w_timer_load = (r_state == ST_CHECK) && (w_state_nxt == ST_LOCK);

    lockout_timer #(
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) u_lockout_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_timer_load),
        .i_en   (r_state == ST_LOCK),
        .o_done (w_timer_done)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; abort outranks confirm, which outranks step.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start)                  w_state_nxt = ST_N0;
                else if (i_prog && i_prog_en) w_state_nxt = ST_P0;
                else                          w_state_nxt = ST_IDLE;
            end
            ST_N0: begin
                if (i_abort)                 w_state_nxt = ST_IDLE;
                else if (i_step && !i_cw)    w_state_nxt = ST_N1;
                else                         w_state_nxt = ST_N0;
            end
            ST_N1: begin
                if (i_abort)                 w_state_nxt = ST_IDLE;
                else if (i_step && i_cw)     w_state_nxt = ST_N2;
                else                         w_state_nxt = ST_N1;
            end
            ST_N2: begin
                if (i_abort)                 w_state_nxt = ST_IDLE;
                else if (i_confirm)          w_state_nxt = ST_CHECK;
                else                         w_state_nxt = ST_N2;
            end
            ST_CHECK: begin
                if (w_pass)                  w_state_nxt = ST_IDLE;
                else if (w_last_fail)        w_state_nxt = ST_LOCK;
                else                         w_state_nxt = ST_IDLE;
            end
            ST_LOCK: begin
                if (w_timer_done)            w_state_nxt = ST_IDLE;
                else                         w_state_nxt = ST_LOCK;
            end
            ST_P0: begin
                if (w_p_cancel)              w_state_nxt = ST_IDLE;
                else if (i_confirm)          w_state_nxt = ST_P1;
                else                         w_state_nxt = ST_P0;
            end
            ST_P1: begin
                if (w_p_cancel)              w_state_nxt = ST_IDLE;
                else if (i_confirm)          w_state_nxt = ST_P2;
                else                         w_state_nxt = ST_P1;
            end
            ST_P2: begin
                if (w_p_cancel)              w_state_nxt = ST_IDLE;
                else if (i_confirm)          w_state_nxt = ST_IDLE;
                else                         w_state_nxt = ST_P2;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: step tracking, number capture, failure count, stored code.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last     <= {DIAL_W{1'b0}};
            r_cap0     <= {DIAL_W{1'b0}};
            r_cap1     <= {DIAL_W{1'b0}};
            r_cap2     <= {DIAL_W{1'b0}};
            r_dir      <= 1'b0;
            r_bad      <= 1'b0;
            r_fail_cnt <= {FC_W{1'b0}};
            r_code0    <= DIAL_W'(CODE0);
            r_code1    <= DIAL_W'(CODE1);
            r_code2    <= DIAL_W'(CODE2);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_dir <= 1'b0;
                        r_bad <= 1'b0;
                    end
                end
                ST_N0: begin
                    // dir still clear on a CCW step means no CW step was seen yet.
                    if (!i_abort && i_step) begin
                        r_last <= i_dial;
                        r_dir  <= i_cw;
                        if (!i_cw) begin
                            if (r_dir) r_cap0 <= r_last;
                            else       r_bad  <= 1'b1;
                        end
                    end
                end
                ST_N1: begin
                    if (!i_abort && i_step) begin
                        r_last <= i_dial;
                        r_dir  <= i_cw;
                        if (i_cw) r_cap1 <= r_last;
                    end
                end
                ST_N2: begin
                    if (!i_abort) begin
                        if (i_confirm) begin
                            r_cap2 <= i_dial;
                        end else if (i_step) begin
                            r_last <= i_dial;
                            r_dir  <= i_cw;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_pass || w_last_fail) r_fail_cnt <= {FC_W{1'b0}};
                    else                       r_fail_cnt <= r_fail_cnt + FC_W'(1);
                end
                ST_P0: if (!w_p_cancel && i_confirm) r_code0 <= i_dial;
                ST_P1: if (!w_p_cancel && i_confirm) r_code1 <= i_dial;
                ST_P2: if (!w_p_cancel && i_confirm) r_code2 <= i_dial;
                default: begin
                end
            endcase
        end
    end

    // Output decode; every output is registered from these next values.
    always_comb begin
        w_clr_nxt       = (r_state == ST_IDLE) && (w_state_nxt != ST_IDLE);
        w_match_nxt     = (r_state == ST_CHECK) && w_pass;
        w_fail_nxt      = (r_state == ST_CHECK) && !w_pass;
        w_prog_done_nxt = (r_state == ST_P2) && !w_p_cancel && i_confirm;
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_clr_count <= 1'b0;
            o_match     <= 1'b0;
            o_fail      <= 1'b0;
            o_prog_done <= 1'b0;
            o_idx       <= 2'd0;
            o_busy      <= 1'b0;
            o_lockout   <= 1'b0;
        end else begin
            o_clr_count <= w_clr_nxt;
            o_match     <= w_match_nxt;
            o_fail      <= w_fail_nxt;
            o_prog_done <= w_prog_done_nxt;
            o_idx       <= state_idx(w_state_nxt);
            o_busy      <= state_busy(w_state_nxt);
            o_lockout   <= (w_state_nxt == ST_LOCK);
        end
    end

endmodule

// File: tb/tb_combo_sequencer.sv
// Directed bench for combo_sequencer: entry, failures, lockout, programming,
// abort, confirm/step collision and mid-attempt reset.
module tb_combo_sequencer;

    logic       clk = 1'b0;
    logic       rst, step, cw, start, confirm, abort_i, prog, prog_en;
    logic [5:0] dial;
    logic       clr_count, match, fail, prog_done, busy, lockout;
    logic [1:0] idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    combo_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_dial(dial), .i_step(step), .i_cw(cw),
        .i_start(start), .i_confirm(confirm), .i_abort(abort_i), .i_prog(prog),
        .i_prog_en(prog_en), .o_clr_count(clr_count), .o_match(match), .o_fail(fail),
        .o_prog_done(prog_done), .o_idx(idx), .o_busy(busy), .o_lockout(lockout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step(input logic [5:0] d, input logic c);
        dial = d; step = 1'b1; cw = c;
        tick();
        step = 1'b0;
    endtask

    task automatic dial_to(input logic [5:0] tgt, input logic c);
        logic [5:0] d;
        for (int n = 0; n < 64 && dial != tgt; n++) begin
            d = c ? dial + 6'd1 : dial - 6'd1;
            do_step(d, c);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0; dial = 6'd0;
    endtask

    task automatic entry(input logic [5:0] c0, input logic [5:0] c1, input logic [5:0] c2, input logic ccw_first);
        pulse_start();
        if (ccw_first) do_step(6'd63, 1'b0);
        dial_to(c0, 1'b1); dial_to(c1, 1'b0); dial_to(c2, 1'b1);
        confirm = 1'b1; tick(); confirm = 1'b0;
    endtask

    task automatic resolve(output logic m, output logic f, output logic l);
        tick();
        m = match; f = fail; l = lockout;
    endtask

    task automatic wait_lockout(output int n, output logic busy_seen);
        n = 0; busy_seen = 1'b0;
        while (lockout === 1'b1 && n < 3000) begin
            if (busy !== 1'b0 || clr_count !== 1'b0) busy_seen = 1'b1;
            start = (n == 10); prog = (n == 20); prog_en = (n == 20); abort_i = (n == 30);
            n++;
            tick();
        end
        start = 1'b0; prog = 1'b0; prog_en = 1'b0; abort_i = 1'b0;
        if (busy !== 1'b0) busy_seen = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; repeat (3) tick();
        checks++;
        if ({clr_count, match, fail, prog_done, idx, busy, lockout} !== 8'd0) begin
            errors++; $display("FAIL reset_outputs: got %b required 00000000", {clr_count, match, fail, prog_done, idx, busy, lockout});
        end
        rst = 1'b0; tick();
        checks++;
        if ({busy, lockout, clr_count} !== 3'b000) begin
            errors++; $display("FAIL idle_after_reset: busy/lockout/clr %b required 000", {busy, lockout, clr_count});
        end
    endtask

    task automatic test_correct_entry();
        logic m, f, l;
        pulse_start();
        checks++;
        if ({clr_count, busy, idx} !== 4'b1100) begin
            errors++; $display("FAIL start_response: clr/busy/idx %b required 1100", {clr_count, busy, idx});
        end
        dial_to(6'd10, 1'b1);
        checks++;
        if (clr_count !== 1'b0 || idx !== 2'd0) begin
            errors++; $display("FAIL n0_tracking: clr=%b idx=%0d required 0 0", clr_count, idx);
        end
        do_step(6'd9, 1'b0);
        checks++;
        if (idx !== 2'd1) begin errors++; $display("FAIL idx_n1: got %0d required 1", idx); end
        dial_to(6'd20, 1'b0);
        do_step(6'd21, 1'b1);
        checks++;
        if (idx !== 2'd2) begin errors++; $display("FAIL idx_n2: got %0d required 2", idx); end
        dial_to(6'd30, 1'b1);
        confirm = 1'b1; tick(); confirm = 1'b0;
        checks++;
        if ({busy, match, fail} !== 3'b100) begin
            errors++; $display("FAIL check_cycle: busy/match/fail %b required 100", {busy, match, fail});
        end
        resolve(m, f, l);
        checks++;
        if ({m, f, l, busy, idx} !== 6'b100000) begin
            errors++; $display("FAIL correct_match: match/fail/lock/busy/idx %b required 100000", {m, f, l, busy, idx});
        end
        tick();
        checks++;
        if (match !== 1'b0) begin errors++; $display("FAIL match_one_cycle: got %b required 0", match); end
    endtask

    task automatic test_wrong_lockout();
        logic m, f, l, bs;
        int n;
        for (int a = 0; a < 3; a++) begin
            entry(6'd10, 6'd21, 6'd30, 1'b0);
            resolve(m, f, l);
            checks++;
            if ({m, f, l} !== {1'b0, 1'b1, (a == 2)}) begin
                errors++; $display("FAIL wrong_attempt_%0d: match/fail/lock %b required 01%0d", a, {m, f, l}, (a == 2));
            end
        end
        wait_lockout(n, bs);
        checks++;
        if (n !== 1000) begin errors++; $display("FAIL lockout_length: got %0d cycles required 1000", n); end
        checks++;
        if (bs !== 1'b0) begin errors++; $display("FAIL lockout_ignores_start: busy seen %b required 0", bs); end
    endtask

    task automatic test_first_ccw();
        logic m, f, l;
        entry(6'd10, 6'd20, 6'd30, 1'b1);
        resolve(m, f, l);
        checks++;
        if ({m, f, l} !== 3'b010) begin
            errors++; $display("FAIL first_ccw: match/fail/lock %b required 010", {m, f, l});
        end
    endtask

    task automatic test_abort_keeps_count();
        logic m, f, l, bs;
        int n;
        pulse_start();
        dial_to(6'd10, 1'b1);
        do_step(6'd9, 1'b0);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        checks++;
        if ({busy, idx, fail} !== 4'b0000) begin
            errors++; $display("FAIL abort_n1: busy/idx/fail %b required 0000", {busy, idx, fail});
        end
        tick();
        checks++;
        if ({fail, busy} !== 2'b00) begin errors++; $display("FAIL abort_no_fail: fail/busy %b required 00", {fail, busy}); end
        // one failure from the CCW test plus two more must now lock out
        entry(6'd10, 6'd21, 6'd30, 1'b0);
        resolve(m, f, l);
        checks++;
        if ({f, l} !== 2'b10) begin errors++; $display("FAIL abort_count_2: fail/lock %b required 10", {f, l}); end
        entry(6'd11, 6'd20, 6'd30, 1'b0);
        resolve(m, f, l);
        checks++;
        if ({f, l} !== 2'b11) begin errors++; $display("FAIL abort_count_3: fail/lock %b required 11", {f, l}); end
        wait_lockout(n, bs);
        checks++;
        if (n !== 1000) begin errors++; $display("FAIL lockout_length_2: got %0d cycles required 1000", n); end
        // a match clears the count: wrong, wrong, right, wrong, wrong never locks
        for (int a = 0; a < 5; a++) begin
            if (a == 2) entry(6'd10, 6'd20, 6'd30, 1'b0);
            else        entry(6'd10, 6'd20, 6'd31, 1'b0);
            resolve(m, f, l);
            checks++;
            if ({m, f, l} !== ((a == 2) ? 3'b100 : 3'b010)) begin
                errors++; $display("FAIL match_clears_count_%0d: match/fail/lock %b", a, {m, f, l});
            end
        end
    endtask

    task automatic test_confirm_with_step();
        logic m, f, l;
        pulse_start();
        dial_to(6'd10, 1'b1); dial_to(6'd20, 1'b0); dial_to(6'd30, 1'b1);
        step = 1'b1; cw = 1'b1; confirm = 1'b1; tick();
        step = 1'b0; confirm = 1'b0; dial = 6'd31;
        resolve(m, f, l);
        checks++;
        if ({m, f} !== 2'b10) begin errors++; $display("FAIL confirm_step: match/fail %b required 10", {m, f}); end
    endtask

    task automatic test_programming();
        logic m, f, l;
        prog = 1'b1; prog_en = 1'b0; tick(); prog = 1'b0;
        checks++;
        if ({busy, clr_count} !== 2'b00) begin errors++; $display("FAIL prog_disabled: busy/clr %b required 00", {busy, clr_count}); end
        prog_en = 1'b1; prog = 1'b1; start = 1'b1; tick(); prog = 1'b0; start = 1'b0;
        dial = 6'd3; confirm = 1'b1; tick(); confirm = 1'b0;
        checks++;
        if ({busy, idx} !== 3'b100) begin errors++; $display("FAIL start_beats_prog: busy/idx %b required 100", {busy, idx}); end
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        prog = 1'b1; tick(); prog = 1'b0;
        checks++;
        if ({clr_count, busy, idx} !== 4'b1100) begin errors++; $display("FAIL prog_enter: clr/busy/idx %b required 1100", {clr_count, busy, idx}); end
        for (int k = 0; k < 3; k++) begin
            dial = 6'(5 + k); confirm = 1'b1; tick(); confirm = 1'b0;
            checks++;
            if ({prog_done, busy, idx} !== ((k == 2) ? 4'b1000 : {2'b01, 2'(k + 1)})) begin
                errors++; $display("FAIL prog_digit_%0d: done/busy/idx %b", k, {prog_done, busy, idx});
            end
        end
        tick();
        checks++;
        if (prog_done !== 1'b0) begin errors++; $display("FAIL prog_done_pulse: got %b required 0", prog_done); end
        prog_en = 1'b0;
        entry(6'd5, 6'd6, 6'd7, 1'b0);
        resolve(m, f, l);
        checks++;
        if ({m, f} !== 2'b10) begin errors++; $display("FAIL new_code_match: match/fail %b required 10", {m, f}); end
        entry(6'd10, 6'd20, 6'd30, 1'b0);
        resolve(m, f, l);
        checks++;
        if ({m, f} !== 2'b01) begin errors++; $display("FAIL old_code_fail: match/fail %b required 01", {m, f}); end
        // partial programming: code0 becomes 9, then permission drops
        prog_en = 1'b1; prog = 1'b1; tick(); prog = 1'b0;
        dial = 6'd9; confirm = 1'b1; tick(); confirm = 1'b0;
        prog_en = 1'b0; tick();
        checks++;
        if ({busy, prog_done} !== 2'b00) begin errors++; $display("FAIL prog_en_drop: busy/done %b required 00", {busy, prog_done}); end
        entry(6'd9, 6'd6, 6'd7, 1'b0);
        resolve(m, f, l);
        checks++;
        if ({m, f} !== 2'b10) begin errors++; $display("FAIL partial_code_match: match/fail %b required 10", {m, f}); end
    endtask

    task automatic test_reset_mid_attempt();
        logic m, f, l;
        entry(6'd1, 6'd2, 6'd3, 1'b0);
        resolve(m, f, l);
        entry(6'd1, 6'd2, 6'd3, 1'b0);
        resolve(m, f, l);
        pulse_start();
        dial_to(6'd10, 1'b1); dial_to(6'd20, 1'b0); dial_to(6'd25, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if ({clr_count, match, fail, prog_done, idx, busy, lockout} !== 8'd0) begin
            errors++; $display("FAIL reset_in_n2: got %b required 00000000", {clr_count, match, fail, prog_done, idx, busy, lockout});
        end
        entry(6'd10, 6'd20, 6'd30, 1'b0);
        resolve(m, f, l);
        checks++;
        if ({m, f} !== 2'b10) begin errors++; $display("FAIL default_code_restored: match/fail %b required 10", {m, f}); end
        entry(6'd10, 6'd20, 6'd33, 1'b0);
        resolve(m, f, l);
        checks++;
        if ({f, l} !== 2'b10) begin errors++; $display("FAIL fail_cnt_restored: fail/lock %b required 10", {f, l}); end
    endtask

    initial begin
        rst = 1'b1; step = 1'b0; cw = 1'b0; start = 1'b0; confirm = 1'b0;
        abort_i = 1'b0; prog = 1'b0; prog_en = 1'b0; dial = 6'd0;
        test_reset();
        test_correct_entry();
        test_wrong_lockout();
        test_first_ccw();
        test_abort_keeps_count();
        test_confirm_with_step();
        test_programming();
        test_reset_mid_attempt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
